// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl
//   Sequential bubble-sort controller. Loads N signed W-bit words over a
//   valid/ready port, sorts them in place with one compare-and-swap per cycle
//   on a single shared signed comparator, then streams them out over a
//   valid/ready port with a last flag.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_data word, in_desc order
//                         (0 ascending, 1 descending, taken with word 0)
//   out_valid/out_ready   output handshake; out_data word, out_last on word N-1
//   busy                  high while sorting or streaming out
//   swap_cnt              swaps performed in the current/last batch
module sort_seq_ctrl #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [W-1:0]                      in_data,
  input  logic                              in_desc,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [W-1:0]                      out_data,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [$clog2(N*(N-1)/2+1)-1:0]    swap_cnt
);

  localparam int IW  = $clog2(N);
  localparam int SCW = $clog2(N*(N-1)/2+1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(N-1);
  localparam logic [IW-1:0] PAIR_LAST = IW'(N-2);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   mem_q [N];
  logic [W-1:0]   mem_d [N];
  logic [IW-1:0]  k_q, k_d;     // load index in LOAD, output index in OUT
  logic [IW-1:0]  j_q, j_d;     // pair index within a pass
  logic [IW-1:0]  p_q, p_d;     // pass number
  logic [SCW-1:0] swap_q, swap_d;
  logic           desc_q, desc_d;

  // Shared comparator: A - B computed as A + ~B + 1. The carry into the MSB
  // comes from a separate (W-1)-bit add so the overflow flag is explicit.
  logic [IW-1:0] j_nx;
  logic [W-1:0]  cmp_a, cmp_b;
  logic [W:0]    diff_full;
  logic [W-1:0]  diff_lo;
  logic [W-1:0]  diff_s;
  logic          cmp_v, cmp_eq, cmp_gt, cmp_lt, do_swap;

  always_comb begin
    j_nx      = j_q + IW'(1);
    cmp_a     = mem_q[j_q];
    cmp_b     = mem_q[j_nx];
    diff_full = {1'b0, cmp_a} + {1'b0, ~cmp_b} + (W+1)'(1);
    diff_lo   = {1'b0, cmp_a[W-2:0]} + {1'b0, ~cmp_b[W-2:0]} + W'(1);
    diff_s    = diff_full[W-1:0];
    cmp_v     = diff_full[W] ^ diff_lo[W-1];
    cmp_eq    = (diff_s == '0);
    cmp_gt    = (~diff_s[W-1] & ~cmp_eq & ~cmp_v) | (diff_s[W-1] & cmp_v);
    cmp_lt    = (diff_s[W-1] & ~cmp_v) | (~diff_s[W-1] & cmp_v);
    do_swap   = desc_q ? cmp_lt : cmp_gt;
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    k_d     = k_q;
    j_d     = j_q;
    p_d     = p_q;
    swap_d  = swap_q;
    desc_d  = desc_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[k_q] = in_data;
          if (k_q == '0) begin
            desc_d = in_desc;
            swap_d = '0;
          end
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            j_d     = '0;
            p_d     = '0;
            state_d = ST_SORT;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end
      ST_SORT: begin
        if (do_swap) begin
          mem_d[j_q]  = cmp_b;
          mem_d[j_nx] = cmp_a;
          swap_d      = swap_q + SCW'(1);
        end
        // Each pass shortens by one since the largest (or smallest) element
        // has bubbled to the end; no early exit, so duration is fixed.
        if (j_q == PAIR_LAST - p_q) begin
          j_d = '0;
          p_d = p_q + IW'(1);
          if (p_q == PAIR_LAST) begin
            state_d = ST_OUT;
            k_d     = '0;
          end
        end else begin
          j_d = j_nx;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            state_d = ST_LOAD;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      k_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      swap_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      k_q     <= k_d;
      j_q     <= j_d;
      p_q     <= p_d;
      swap_q  <= swap_d;
      desc_q  <= desc_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_OUT);
    out_data  = mem_q[k_q];
    out_last  = (state_q == ST_OUT) && (k_q == LAST_IDX);
    busy      = (state_q == ST_SORT) || (state_q == ST_OUT);
    swap_cnt  = swap_q;
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl
//   Directed-vector bench for sort_seq_ctrl (W=8, N=4) with hand-computed
//   expected outputs, swap counts and latency.
module tb_sort_seq_ctrl;

  typedef logic [7:0] batch_t [4];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_desc;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic [2:0] swap_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sort_seq_ctrl #(.W(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Entered and left at posedge+1. Presents the four words; each is taken on
  // the first edge where in_ready is seen high.
  task automatic send_batch(input batch_t b, input logic desc);
    for (int i = 0; i < 4; i++) begin
      int t;
      in_valid = 1'b1;
      in_data  = b[i];
      in_desc  = desc;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the last accept edge (posedge+1); counts cycles until
  // out_valid is first observed.
  task automatic wait_first_out(input int exp_cyc);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_cyc));
  endtask

  // Drains one batch. stall[k] inserts one out_ready=0 cycle before word k.
  task automatic collect(input batch_t e, input logic [3:0] stall, input logic [2:0] exp_swaps);
    for (int k = 0; k < 4; k++) begin
      int t;
      if (stall[k]) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_data", 32'(out_data), 32'(e[k]));
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data2", 32'(out_data), 32'(e[k]));
      end
      out_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 60) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(e[k]));
      chk("out_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      chk("busy_out", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    chk("swap_cnt", 32'(swap_cnt), 32'(exp_swaps));
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    batch_t a, e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_desc   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_swap", 32'(swap_cnt), 32'd0);
    rst_n = 1'b1;

    // Ascending with overflow pair -128/127; out_ready held high throughout.
    out_ready = 1'b1;
    a = '{8'h05, 8'hFD, 8'h7F, 8'h80};
    e = '{8'h80, 8'hFD, 8'h05, 8'h7F};
    send_batch(a, 1'b0);
    chk("sort_busy", 32'(busy), 32'd1);
    chk("sort_in_ready", 32'(in_ready), 32'd0);
    wait_first_out(7);
    collect(e, 4'b0000, 3'd4);

    // Descending, same data.
    e = '{8'h7F, 8'h05, 8'hFD, 8'h80};
    send_batch(a, 1'b1);
    wait_first_out(7);
    collect(e, 4'b0000, 3'd2);

    // All equal: no swaps, SORT duration unchanged.
    a = '{8'd9, 8'd9, 8'd9, 8'd9};
    send_batch(a, 1'b0);
    wait_first_out(7);
    collect(a, 4'b0000, 3'd0);

    // Already sorted with output stalls.
    a = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_batch(a, 1'b0);
    wait_first_out(7);
    collect(a, 4'b1010, 3'd0);

    // Reset mid-sort after three compares (two swaps by then).
    a = '{8'h05, 8'hFD, 8'h7F, 8'h80};
    send_batch(a, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_swap", 32'(swap_cnt), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_swap", 32'(swap_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    a = '{8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_batch(a, 1'b0);
    wait_first_out(7);
    collect(e, 4'b0000, 3'd6);

    // Back-to-back: in_valid stays high with the next batch's first word
    // while the previous batch drains; it must not be taken until LOAD.
    a = '{8'd10, 8'hEC, 8'd30, 8'hD8};
    e = '{8'hD8, 8'hEC, 8'd10, 8'd30};
    send_batch(a, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_desc  = 1'b1;
    wait_first_out(7);
    collect(e, 4'b0000, 3'd4);
    a = '{8'hFF, 8'h00, 8'hFF, 8'h01};
    e = '{8'h01, 8'h00, 8'hFF, 8'hFF};
    send_batch(a, 1'b1);
    wait_first_out(7);
    collect(e, 4'b0000, 3'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
